// File: rtl/kd_pkg.sv
// Shared constants and mode encoding for the Kyber/Dilithium butterfly datapath.
package kd_pkg;

  localparam int unsigned KD_KQ = 3329;
  localparam int unsigned KD_DQ = 8380417;
  localparam int unsigned KD_KW = 12;
  localparam int unsigned KD_DW = 24;

  typedef enum logic {
    KD_KYBER = 1'b0,
    KD_DIL   = 1'b1
  } kd_mode_e;

endpackage

// File: rtl/kd_mod_half.sv
// Combinational modular halving: x/2 mod Q for x < Q (odd x is lifted by Q first).
module kd_mod_half #(
  parameter int unsigned W = 12,
  parameter int unsigned Q = 3329
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  localparam logic [W:0] QW = (W+1)'(Q);

  logic [W:0] t;

  always_comb begin
    t   = {1'b0, x_i} + (x_i[0] ? QW : '0);
    y_o = W'(t >> 1);
  end

endmodule

// File: rtl/kd_butterfly_gs_half.sv
// Gentleman-Sande butterfly front end: (a+b)/2 and (a-b)/2 mod q, two Kyber lanes or one Dilithium lane.
// Halving stage is enabled by defining KD_INTT_DIV2_EN; otherwise stage 2 just registers the mod sum/diff.
module kd_butterfly_gs_half
  import kd_pkg::*;
#(
  parameter int unsigned KQ = 3329,
  parameter int unsigned DQ = 8380417
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              KD_mode,
  input  logic [KD_DW-1:0]  a,
  input  logic [KD_DW-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KD_DW-1:0]  out_sum,
  output logic [KD_DW-1:0]  out_diff
);

  localparam logic [KD_KW:0]   KQ_K = (KD_KW+1)'(KQ);
  localparam logic [KD_DW-1:0] DQ_D = KD_DW'(DQ);

  kd_mode_e          mode_in;
  logic              advance;

  logic              v1_q, v2_q;
  kd_mode_e          mode1_q;
  logic [KD_DW-1:0]  sum1_q, diff1_q, sum1_d, diff1_d;
  logic [KD_DW-1:0]  sum2_q, diff2_q, sum2_d, diff2_d;

  logic [KD_KW:0]    ks_l, ks_h, kd_l, kd_h;
  logic [KD_DW-1:0]  ds, dd;

  assign mode_in  = kd_mode_e'(KD_mode);
  assign advance  = !(v2_q && !out_ready);
  assign in_ready = advance;

  // Stage 1: per-lane modular add/sub; Dilithium ignores input bit 23.
  always_comb begin
    ks_l = {1'b0, a[11:0]} + {1'b0, b[11:0]};
    if (ks_l >= KQ_K) ks_l = ks_l - KQ_K;
    ks_h = {1'b0, a[23:12]} + {1'b0, b[23:12]};
    if (ks_h >= KQ_K) ks_h = ks_h - KQ_K;
    kd_l = {1'b0, a[11:0]} - {1'b0, b[11:0]};
    if (kd_l[KD_KW]) kd_l = kd_l + KQ_K;
    kd_h = {1'b0, a[23:12]} - {1'b0, b[23:12]};
    if (kd_h[KD_KW]) kd_h = kd_h + KQ_K;

    ds = {1'b0, a[22:0]} + {1'b0, b[22:0]};
    if (ds >= DQ_D) ds = ds - DQ_D;
    dd = {1'b0, a[22:0]} - {1'b0, b[22:0]};
    if (dd[KD_DW-1]) dd = dd + DQ_D;

    if (mode_in == KD_DIL) begin
      sum1_d  = ds;
      diff1_d = dd;
    end else begin
      sum1_d  = {ks_h[KD_KW-1:0], ks_l[KD_KW-1:0]};
      diff1_d = {kd_h[KD_KW-1:0], kd_l[KD_KW-1:0]};
    end
  end

`ifdef KD_INTT_DIV2_EN
  logic [KD_KW-1:0] hs_kl, hs_kh, hd_kl, hd_kh;
  logic [22:0]      hs_d, hd_d;

  kd_mod_half #(.W(KD_KW), .Q(KQ)) u_hs_kl (.x_i(sum1_q[11:0]),   .y_o(hs_kl));
  kd_mod_half #(.W(KD_KW), .Q(KQ)) u_hs_kh (.x_i(sum1_q[23:12]),  .y_o(hs_kh));
  kd_mod_half #(.W(KD_KW), .Q(KQ)) u_hd_kl (.x_i(diff1_q[11:0]),  .y_o(hd_kl));
  kd_mod_half #(.W(KD_KW), .Q(KQ)) u_hd_kh (.x_i(diff1_q[23:12]), .y_o(hd_kh));
  kd_mod_half #(.W(23),    .Q(DQ)) u_hs_d  (.x_i(sum1_q[22:0]),   .y_o(hs_d));
  kd_mod_half #(.W(23),    .Q(DQ)) u_hd_d  (.x_i(diff1_q[22:0]),  .y_o(hd_d));

  always_comb begin
    if (mode1_q == KD_DIL) begin
      sum2_d  = {1'b0, hs_d};
      diff2_d = {1'b0, hd_d};
    end else begin
      sum2_d  = {hs_kh, hs_kl};
      diff2_d = {hd_kh, hd_kl};
    end
  end
`else
  // Bit 23 is cleared here so out-of-range Dilithium operands cannot leak into it.
  always_comb begin
    if (mode1_q == KD_DIL) begin
      sum2_d  = {1'b0, sum1_q[22:0]};
      diff2_d = {1'b0, diff1_q[22:0]};
    end else begin
      sum2_d  = sum1_q;
      diff2_d = diff1_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= KD_KYBER;
      sum1_q  <= '0;
      diff1_q <= '0;
      sum2_q  <= '0;
      diff2_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        mode1_q <= mode_in;
        sum1_q  <= sum1_d;
        diff1_q <= diff1_d;
      end
      if (v1_q) begin
        sum2_q  <= sum2_d;
        diff2_q <= diff2_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_sum   = sum2_q;
  assign out_diff  = diff2_q;

endmodule

// File: tb/tb_kd_butterfly_gs_half.sv
// Self-checking bench for kd_butterfly_gs_half; expectations follow KD_INTT_DIV2_EN like the DUT.
module tb_kd_butterfly_gs_half;

  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        KD_mode = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sum, out_diff;

  kd_butterfly_gs_half #(.KQ(3329), .DQ(8380417)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .KD_mode(KD_mode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_diff(out_diff)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: halving is multiplication by the inverse of 2 mod q.
  function automatic longint half_mod(input longint x, input longint q);
`ifdef KD_INTT_DIV2_EN
    return (x * ((q + 1) / 2)) % q;
`else
    return x;
`endif
  endfunction

  function automatic void model(input logic m, input logic [23:0] ia, input logic [23:0] ib,
                                output logic [23:0] s, output logic [23:0] d);
    longint xa, xb;
    s = '0;
    d = '0;
    if (m) begin
      xa = longint'(ia & 24'h7FFFFF);
      xb = longint'(ib & 24'h7FFFFF);
      s = 24'(half_mod((xa + xb) % DQ, DQ));
      d = 24'(half_mod((xa - xb + DQ) % DQ, DQ));
    end else begin
      for (int l = 0; l < 2; l++) begin
        xa = longint'((ia >> (12 * l)) & 24'hFFF);
        xb = longint'((ib >> (12 * l)) & 24'hFFF);
        s[12*l +: 12] = 12'(half_mod((xa + xb) % KQ, KQ));
        d[12*l +: 12] = 12'(half_mod((xa - xb + KQ) % KQ, KQ));
      end
    end
  endfunction

`ifdef KD_INTT_DIV2_EN
  function automatic bit twice_ok(input logic m, input logic [23:0] o, input logic [23:0] ia,
                                  input logic [23:0] ib, input bit sub);
    longint q, xo, xa, xb, rhs;
    bit ok = 1'b1;
    for (int l = 0; l < (m ? 1 : 2); l++) begin
      q  = m ? DQ : KQ;
      xo = m ? longint'(o) : longint'((o >> (12 * l)) & 24'hFFF);
      xa = m ? longint'(ia & 24'h7FFFFF) : longint'((ia >> (12 * l)) & 24'hFFF);
      xb = m ? longint'(ib & 24'h7FFFFF) : longint'((ib >> (12 * l)) & 24'hFFF);
      rhs = sub ? (xa - xb + q) % q : (xa + xb) % q;
      if ((2 * xo) % q != rhs) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

  typedef struct {
    logic        m;
    logic [23:0] a, b, s, d;
  } beat_t;

  beat_t sb[$];
  bit    mon_en = 1'b0;
  bit    stalled = 1'b0;
  logic [23:0] held_s, held_d;
  int    rcv = 0;

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && !rst) begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_sum", 32'(out_sum), 32'(held_s));
        chk("hold_diff", 32'(out_diff), 32'(held_d));
      end
      stalled = out_valid && !out_ready;
      held_s  = out_sum;
      held_d  = out_diff;
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        rcv++;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("stream_sum", 32'(out_sum), 32'(e.s));
          chk("stream_diff", 32'(out_diff), 32'(e.d));
`ifdef KD_INTT_DIV2_EN
          chk("twice_sum", 32'(twice_ok(e.m, out_sum, e.a, e.b, 1'b0)), 1);
          chk("twice_diff", 32'(twice_ok(e.m, out_diff, e.a, e.b, 1'b1)), 1);
`endif
        end
      end
      if (in_valid && in_ready) begin
        e.m = KD_mode; e.a = a; e.b = b;
        model(KD_mode, a, b, e.s, e.d);
        sb.push_back(e);
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic gen_beat(input logic m);
    KD_mode = m;
    if (m) begin
      a = {1'($urandom_range(0, 1)), 23'($urandom_range(0, DQ - 1))};
      b = {1'($urandom_range(0, 1)), 23'($urandom_range(0, DQ - 1))};
    end else begin
      a = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
      b = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    end
  endtask

  // rnd=0: alternating modes, out_ready pattern 1,0,0,1; rnd=1: random modes/ready/gaps.
  task automatic stream(input int n, input bit rnd);
    int pat[4] = '{1, 0, 0, 1};
    int sent = 0;
    int cyc = 0;
    bit pending = 1'b0;
    while (sent < n && cyc < n * 20 + 100) begin
      @(posedge clk); #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : (pat[cyc % 4] != 0);
      if (!pending && (!rnd || $urandom_range(0, 99) >= 20)) begin
        gen_beat(rnd ? 1'($urandom_range(0, 1)) : 1'(sent % 2));
        pending = 1'b1;
      end
      in_valid = pending;
      @(negedge clk);
      if (in_valid && in_ready) begin
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", 32'(sent), 32'(n));
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_empty", 32'(sb.size()), 0);
  endtask

  typedef struct {
    logic        m;
    logic [23:0] a, b, es, ed;
  } vec_t;

  vec_t vt[6];

  task automatic set_vec(input int i, input logic m, input logic [23:0] va, input logic [23:0] vb,
                         input logic [23:0] es, input logic [23:0] ed);
    vt[i].m = m; vt[i].a = va; vt[i].b = vb; vt[i].es = es; vt[i].ed = ed;
  endtask

  initial begin
    int seen;
`ifdef KD_INTT_DIV2_EN
    set_vec(0, 1'b0, {12'd3328, 12'd3328}, {12'd3328, 12'd1}, {12'd3328, 12'd0}, {12'd0, 12'd3328});
    set_vec(1, 1'b0, {12'd0, 12'd0},       {12'd0, 12'd1},    {12'd0, 12'd1665}, {12'd0, 12'd1664});
    set_vec(2, 1'b1, 24'd8380416,          24'd1,             24'd0,             24'd8380416);
    set_vec(3, 1'b1, 24'h800005,           24'd3,             24'd4,             24'd1);
    set_vec(4, 1'b0, {12'd1, 12'd3328},    {12'd0, 12'd3328}, {12'd1665, 12'd3328}, {12'd1665, 12'd0});
    set_vec(5, 1'b1, 24'd0,                24'd8380416,       24'd4190208,       24'd4190209);
`else
    set_vec(0, 1'b0, {12'd3328, 12'd3328}, {12'd3328, 12'd1}, {12'd3327, 12'd0}, {12'd0, 12'd3327});
    set_vec(1, 1'b0, {12'd0, 12'd0},       {12'd0, 12'd1},    {12'd0, 12'd1},    {12'd0, 12'd3328});
    set_vec(2, 1'b1, 24'd8380416,          24'd1,             24'd0,             24'd8380415);
    set_vec(3, 1'b1, 24'h800005,           24'd3,             24'd8,             24'd2);
    set_vec(4, 1'b0, {12'd1, 12'd3328},    {12'd0, 12'd3328}, {12'd1, 12'd3327}, {12'd1, 12'd0});
    set_vec(5, 1'b1, 24'd0,                24'd8380416,       24'd8380416,       24'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_diff", 32'(out_diff), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      KD_mode = vt[i].m; a = vt[i].a; b = vt[i].b;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1", i), 32'(out_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_lat2", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vt[i].es));
      chk($sformatf("vec%0d_diff", i), 32'(out_diff), 32'(vt[i].ed));
    end
    @(posedge clk); #1;

    mon_en = 1'b1;
    rcv = 0;
    stream(8, 1'b0);
    chk("bp_received", 32'(rcv), 8);
    mon_en = 1'b0;

    // Two beats in flight, then a one-cycle reset must drop both.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; KD_mode = 1'b0;
    a = {12'd5, 12'd6}; b = {12'd7, 12'd8};
    @(posedge clk); #1;
    KD_mode = 1'b1; a = 24'd100; b = 24'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_inflight", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_sum", 32'(out_sum), 0);
    chk("mid_rst_out_diff", 32'(out_diff), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_ghost", 32'(seen), 0);

    sb.delete();
    mon_en = 1'b1;
    rcv = 0;
    stream(10000, 1'b1);
    chk("rnd_received", 32'(rcv), 10000);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
